// File: rtl/gt_pattern_loader_ctrl.sv
// Command sequencer that loads the per-lane GT pattern SRAMs row by row and
// drives the playback enable and stretched clear pulse toward the GT data path.
module gt_pattern_loader_ctrl #(
    parameter int NUM_LANES   = 6,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int RST_STRETCH = 8
) (
    input  logic              axilite_clk,
    input  logic              axilite_rstb,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    output logic [3:0]        ram_idx,
    output logic              reg_start,
    output logic              reg_reset,
    output logic [ADDR_W:0]   rows,
    output logic              err,
    output logic [1:0]        state
);

    localparam int ROWS   = 2 ** ADDR_W;
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W  = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;

    localparam logic [1:0] OP_PUSH  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CLR  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_ptr_q, lane_ptr_d;
    logic [ADDR_W:0]     row_ptr_q, row_ptr_d;
    logic [CNT_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic                err_q, err_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_data_q, ram_data_d;
    logic [3:0]          ram_idx_q, ram_idx_d;
    logic                reg_start_q, reg_start_d;
    logic                reg_reset_q, reg_reset_d;
    logic                cmd_ready_q, cmd_ready_d;

    // Handshake: a command is consumed on every rising edge where
    // cmd_valid && cmd_ready; cmd_ready is registered and low while clearing.
    logic cmd_fire;
    logic full;
    logic row_last_lane;
    logic start_ok;
    logic clr_done;

    assign cmd_fire      = cmd_valid && cmd_ready_q;
    assign full          = (row_ptr_q == (ADDR_W + 1)'(ROWS));
    assign row_last_lane = (lane_ptr_q == LANE_W'(NUM_LANES - 1));
    assign start_ok      = (row_ptr_q != '0) && (lane_ptr_q == '0);
    assign clr_done      = (clr_cnt_q == '0);

    // State register
    always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
        if (!axilite_rstb) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire && cmd_op == OP_CLEAR) begin
                    state_d = ST_CLR;
                end else if (cmd_fire && cmd_op == OP_START && start_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cmd_fire && cmd_op == OP_CLEAR) begin
                    state_d = ST_CLR;
                end else if (cmd_fire && cmd_op == OP_STOP) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLR: begin
                if (clr_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values; everything visible outside is registered.
    always_comb begin
        lane_ptr_d  = lane_ptr_q;
        row_ptr_d   = row_ptr_q;
        clr_cnt_d   = clr_cnt_q;
        err_d       = err_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        ram_idx_d   = ram_idx_q;
        reg_start_d = (state_d == ST_RUN);
        reg_reset_d = (state_d == ST_CLR);
        cmd_ready_d = (state_d != ST_CLR);

        if (state_q == ST_CLR) begin
            if (!clr_done) begin
                clr_cnt_d = clr_cnt_q - 1'b1;
            end
        end else if (cmd_fire) begin
            case (cmd_op)
                OP_PUSH: begin
                    // SRAMs are frozen while playing and never wrap once full.
                    if (state_q == ST_IDLE && !full) begin
                        ram_we_d   = 1'b1;
                        ram_idx_d  = 4'(lane_ptr_q);
                        ram_addr_d = row_ptr_q[ADDR_W-1:0];
                        ram_data_d = cmd_data;
                        if (row_last_lane) begin
                            lane_ptr_d = '0;
                            row_ptr_d  = row_ptr_q + 1'b1;
                        end else begin
                            lane_ptr_d = lane_ptr_q + 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_START: begin
                    if (state_q == ST_IDLE && !start_ok) begin
                        err_d = 1'b1;
                    end
                end
                OP_STOP: begin
                end
                OP_CLEAR: begin
                    lane_ptr_d = '0;
                    row_ptr_d  = '0;
                    err_d      = 1'b0;
                    clr_cnt_d  = CNT_W'(RST_STRETCH - 1);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
        if (!axilite_rstb) begin
            lane_ptr_q  <= '0;
            row_ptr_q   <= '0;
            clr_cnt_q   <= '0;
            err_q       <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            ram_idx_q   <= '0;
            reg_start_q <= 1'b0;
            reg_reset_q <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            lane_ptr_q  <= lane_ptr_d;
            row_ptr_q   <= row_ptr_d;
            clr_cnt_q   <= clr_cnt_d;
            err_q       <= err_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            ram_idx_q   <= ram_idx_d;
            reg_start_q <= reg_start_d;
            reg_reset_q <= reg_reset_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign ram_we    = ram_we_q;
    assign ram_idx   = ram_idx_q;
    assign reg_start = reg_start_q;
    assign reg_reset = reg_reset_q;
    assign rows      = row_ptr_q;
    assign err       = err_q;
    assign state     = state_q;

    // Invariants the GT data path relies on.
    a_no_we_in_reset: assert property (@(posedge axilite_clk) disable iff (!axilite_rstb)
        !(ram_we_q && reg_reset_q));
    a_ready_vs_clr: assert property (@(posedge axilite_clk) disable iff (!axilite_rstb)
        (state_q == ST_CLR) |-> !cmd_ready_q);
    a_rows_bound: assert property (@(posedge axilite_clk) disable iff (!axilite_rstb)
        row_ptr_q <= (ADDR_W + 1)'(ROWS));

endmodule
